// File: rtl/vote_tally_multi.sv
// vote_tally_multi: multi-candidate ballot counter with one-ballot-per-press
// handshake, saturating per-candidate counters and a serial winner scan.
//
// Optional feature: define VOTE_TALLY_INVALID_CNT_EN to add the refused-ballot
// counter (invalid_cnt port + register). Default build omits both.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   open_i         start election (clears all tallies)
//   close_i        end election (starts winner scan)
//   cast, sel      ballot strobe and one-hot candidate select
//   vote_ack/rej   one-cycle pulses after a ballot is counted / refused
//   counts         packed per-candidate counters, candidate i at [i*CNT_W +: CNT_W]
//   total          number of accepted ballots
//   state          00 IDLE, 01 OPEN, 10 HOLD, 11 CLOSED
//   winner, tie    result of the scan, valid while result_valid=1
//   invalid_cnt    saturating count of malformed ballots (feature build only)
module vote_tally_multi #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      open_i,
    input  logic                      close_i,
    input  logic                      cast,
    input  logic [NUM_CAND-1:0]       sel,
    output logic                      vote_ack,
    output logic                      vote_rej,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [CNT_W+3:0]          total,
    output logic [1:0]                state,
    output logic [3:0]                winner,
    output logic                      tie,
    output logic                      result_valid
`ifdef VOTE_TALLY_INVALID_CNT_EN
    ,
    output logic [CNT_W-1:0]          invalid_cnt
`endif
);

    localparam int unsigned IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int unsigned TOT_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OPEN   = 2'b01,
        HOLD   = 2'b10,
        CLOSED = 2'b11
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt [NUM_CAND];

    // Winner-scan bookkeeping
    logic             scanning;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic             run_tie;

    // Ballot decode and scan-step results
    logic             sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_full;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_tie;

    assign state = st;

    // Flatten counters onto the packed output bus
    always_comb begin
        counts = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            counts[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    // One-hot check, selected candidate, and one step of the running-max scan
    always_comb begin
        sel_onehot = (sel != '0) && ((sel & (sel - NUM_CAND'(1))) == '0);
        sel_idx    = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
        sel_full = (cnt[sel_idx] == CNT_MAX);

        cand    = cnt[scan_idx];
        nxt_max = run_max;
        nxt_idx = run_idx;
        nxt_tie = run_tie;
        if (scan_idx == '0) begin
            nxt_max = cand;
            nxt_idx = '0;
            nxt_tie = 1'b0;
        end else if (cand > run_max) begin
            // strictly greater only: equal maxima keep the lower index
            nxt_max = cand;
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if (cand == run_max) begin
            nxt_tie = 1'b1;
        end
    end

    // Election FSM, tallies and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
            total        <= '0;
            vote_ack     <= 1'b0;
            vote_rej     <= 1'b0;
            winner       <= '0;
            tie          <= 1'b0;
            result_valid <= 1'b0;
            scanning     <= 1'b0;
            scan_idx     <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            run_tie      <= 1'b0;
`ifdef VOTE_TALLY_INVALID_CNT_EN
            invalid_cnt  <= '0;
`endif
        end else begin
            vote_ack <= 1'b0;
            vote_rej <= 1'b0;
            case (st)
                IDLE, CLOSED: begin
                    if (open_i) begin
                        // new election: wipe tallies and any in-flight scan
                        st           <= OPEN;
                        for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
                        total        <= '0;
                        winner       <= '0;
                        tie          <= 1'b0;
                        result_valid <= 1'b0;
                        scanning     <= 1'b0;
                        scan_idx     <= '0;
`ifdef VOTE_TALLY_INVALID_CNT_EN
                        invalid_cnt  <= '0;
`endif
                    end else if (st == CLOSED && scanning) begin
                        run_max  <= nxt_max;
                        run_idx  <= nxt_idx;
                        run_tie  <= nxt_tie;
                        scan_idx <= scan_idx + IDX_W'(1);
                        if (scan_idx == LAST_IDX) begin
                            scanning     <= 1'b0;
                            result_valid <= 1'b1;
                            winner       <= 4'(nxt_idx);
                            tie          <= nxt_tie;
                        end
                    end
                end
                OPEN: begin
                    if (cast) begin
                        if (sel_onehot && !sel_full) begin
                            cnt[sel_idx] <= cnt[sel_idx] + CNT_W'(1);
                            total        <= total + TOT_W'(1);
                            vote_ack     <= 1'b1;
                        end else begin
                            vote_rej <= 1'b1;
`ifdef VOTE_TALLY_INVALID_CNT_EN
                            // saturated-candidate refusals are not malformed ballots
                            if (!sel_onehot && invalid_cnt != CNT_MAX) begin
                                invalid_cnt <= invalid_cnt + CNT_W'(1);
                            end
`endif
                        end
                    end
                    if (close_i) begin
                        st       <= CLOSED;
                        scanning <= 1'b1;
                        scan_idx <= '0;
                    end else if (cast) begin
                        st <= HOLD;
                    end
                end
                HOLD: begin
                    if (close_i) begin
                        st       <= CLOSED;
                        scanning <= 1'b1;
                        scan_idx <= '0;
                    end else if (!cast && sel == '0) begin
                        st <= OPEN;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_tally_multi.sv
// Bench for vote_tally_multi: two instances (CNT_W=8 and CNT_W=2) share the
// same stimulus; each is checked every cycle against an array-based model.
module tb_vote_tally_multi;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic open_i, close_i, cast;
    logic [N-1:0] sel;

    logic        ack0, rej0, tie0, rv0;
    logic [31:0] counts0;
    logic [11:0] total0;
    logic [1:0]  st0;
    logic [3:0]  win0;
    logic        ack1, rej1, tie1, rv1;
    logic [7:0]  counts1;
    logic [5:0]  total1;
    logic [1:0]  st1;
    logic [3:0]  win1;
`ifdef VOTE_TALLY_INVALID_CNT_EN
    logic [7:0]  inv0;
    logic [1:0]  inv1;
`endif

    always #5 clk = ~clk;

    vote_tally_multi #(.NUM_CAND(N), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .open_i(open_i), .close_i(close_i), .cast(cast), .sel(sel),
        .vote_ack(ack0), .vote_rej(rej0), .counts(counts0), .total(total0), .state(st0),
        .winner(win0), .tie(tie0), .result_valid(rv0)
`ifdef VOTE_TALLY_INVALID_CNT_EN
        , .invalid_cnt(inv0)
`endif
    );

    vote_tally_multi #(.NUM_CAND(N), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .open_i(open_i), .close_i(close_i), .cast(cast), .sel(sel),
        .vote_ack(ack1), .vote_rej(rej1), .counts(counts1), .total(total1), .state(st1),
        .winner(win1), .tie(tie1), .result_valid(rv1)
`ifdef VOTE_TALLY_INVALID_CNT_EN
        , .invalid_cnt(inv1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // state codes: 0 idle, 1 open, 2 hold (waiting for release), 3 closed
    int m_state [2];
    int m_cnt   [2][N];
    int m_total [2];
    int m_inv   [2];
    int m_ack   [2];
    int m_rej   [2];
    int m_rv    [2];
    int m_win   [2];
    int m_tie   [2];
    int m_since [2];
    int cmax    [2] = '{255, 3};

    function automatic void m_clear(int k, int to_state);
        m_state[k] = to_state;
        for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
        m_total[k] = 0; m_inv[k] = 0; m_ack[k] = 0; m_rej[k] = 0;
        m_rv[k] = 0; m_win[k] = 0; m_tie[k] = 0; m_since[k] = 0;
    endfunction

    function automatic void m_result(int k);
        int mx, nmax;
        mx = 0;
        for (int i = 0; i < N; i++) if (m_cnt[k][i] > mx) mx = m_cnt[k][i];
        nmax = 0;
        m_win[k] = -1;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[k][i] == mx) begin
                nmax++;
                if (m_win[k] < 0) m_win[k] = i;
            end
        end
        m_tie[k] = (nmax > 1) ? 1 : 0;
        m_rv[k]  = 1;
    endfunction

    function automatic void m_step(int k, bit o, bit c, bit ca, logic [N-1:0] s);
        int ones, idx;
        m_ack[k] = 0;
        m_rej[k] = 0;
        case (m_state[k])
            0: if (o) m_clear(k, 1);
            3: begin
                if (o) m_clear(k, 1);
                else if (m_since[k] < N) begin
                    m_since[k]++;
                    if (m_since[k] == N) m_result(k);
                end
            end
            1: begin
                if (ca) begin
                    ones = $countones(s);
                    idx = 0;
                    for (int i = 0; i < N; i++) if (s[i]) idx = i;
                    if (ones == 1 && m_cnt[k][idx] < cmax[k]) begin
                        m_cnt[k][idx]++;
                        m_total[k]++;
                        m_ack[k] = 1;
                    end else begin
                        m_rej[k] = 1;
                        if (ones != 1 && m_inv[k] < cmax[k]) m_inv[k]++;
                    end
                end
                if (c) begin m_state[k] = 3; m_since[k] = 0; end
                else if (ca) m_state[k] = 2;
            end
            default: begin
                if (c) begin m_state[k] = 3; m_since[k] = 0; end
                else if (!ca && s == '0) m_state[k] = 1;
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear(0, 0);
            m_clear(1, 0);
        end else begin
            m_step(0, open_i, close_i, cast, sel);
            m_step(1, open_i, close_i, cast, sel);
        end
    end

    // ---------------- per-cycle compare ----------------
    function automatic int act_cnt(int k, int i);
        return (k == 0) ? int'(counts0[i*8 +: 8]) : int'(counts1[i*2 +: 2]);
    endfunction

    function automatic void cmp(int k);
        int a_st, a_ack, a_rej, a_tot, a_rv, a_win, a_tie;
        a_st  = (k == 0) ? int'(st0)    : int'(st1);
        a_ack = (k == 0) ? int'(ack0)   : int'(ack1);
        a_rej = (k == 0) ? int'(rej0)   : int'(rej1);
        a_tot = (k == 0) ? int'(total0) : int'(total1);
        a_rv  = (k == 0) ? int'(rv0)    : int'(rv1);
        a_win = (k == 0) ? int'(win0)   : int'(win1);
        a_tie = (k == 0) ? int'(tie0)   : int'(tie1);
        chk($sformatf("i%0d_state", k), a_st, m_state[k]);
        chk($sformatf("i%0d_ack", k), a_ack, m_ack[k]);
        chk($sformatf("i%0d_rej", k), a_rej, m_rej[k]);
        chk($sformatf("i%0d_total", k), a_tot, m_total[k]);
        chk($sformatf("i%0d_result_valid", k), a_rv, m_rv[k]);
        chk($sformatf("i%0d_winner", k), a_win, m_rv[k] ? m_win[k] : 0);
        chk($sformatf("i%0d_tie", k), a_tie, m_rv[k] ? m_tie[k] : 0);
        for (int i = 0; i < N; i++) chk($sformatf("i%0d_count%0d", k, i), act_cnt(k, i), m_cnt[k][i]);
`ifdef VOTE_TALLY_INVALID_CNT_EN
        chk($sformatf("i%0d_invalid_cnt", k), (k == 0) ? int'(inv0) : int'(inv1), m_inv[k]);
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(bit o, bit c, bit ca, logic [N-1:0] s);
        open_i = o; close_i = c; cast = ca; sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic vote(logic [N-1:0] s);
        step(1'b0, 1'b0, 1'b1, s);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        open_i = 0; close_i = 0; cast = 0; sel = '0; rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("lit_reset_state", int'(st0), 0);
        chk("lit_reset_total", int'(total0), 0);
        rst = 1'b0;
        step(0, 0, 0, '0);

        // single valid ballot and release
        step(1, 0, 0, '0);
        @(negedge clk); chk("lit_open_state", int'(st0), 1);
        step(0, 0, 1, 4'b0010);
        @(negedge clk);
        chk("lit_ack_pulse", int'(ack0), 1);
        chk("lit_hold_state", int'(st0), 2);
        step(0, 0, 0, '0);
        @(negedge clk);
        chk("lit_cnt1", int'(counts0[15:8]), 1);
        chk("lit_total1", int'(total0), 1);
        chk("lit_back_open", int'(st0), 1);
        chk("lit_ack_one_cycle", int'(ack0), 0);

        // held cast counts once; multi-hot refused
        repeat (5) step(0, 0, 1, 4'b0001);
        step(0, 0, 0, '0);
        @(negedge clk);
        chk("lit_held_cnt0", int'(counts0[7:0]), 1);
        chk("lit_held_total", int'(total0), 2);
        step(0, 0, 1, 4'b0110);
        @(negedge clk);
        chk("lit_multihot_rej", int'(rej0), 1);
        chk("lit_multihot_total", int'(total0), 2);
`ifdef VOTE_TALLY_INVALID_CNT_EN
        chk("lit_invalid_cnt", int'(inv0), 1);
`endif
        step(0, 0, 0, '0);

        // fresh election: saturation in the 2-bit instance
        step(0, 1, 0, '0);
        repeat (5) step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        repeat (3) vote(4'b0100);
        step(0, 0, 1, 4'b0100);
        @(negedge clk);
        chk("lit_sat_rej", int'(rej1), 1);
        chk("lit_sat_wide_ack", int'(ack0), 1);
        step(0, 0, 0, '0);
        @(negedge clk);
        chk("lit_sat_cnt2", int'(counts1[5:4]), 3);
        chk("lit_sat_total", int'(total1), 3);
        chk("lit_wide_cnt2", int'(counts0[23:16]), 4);

        // votes 3,5,5,1 then close (open mid-scan abandons the scan)
        step(0, 1, 0, '0);
        step(1, 0, 0, '0);
        repeat (3) vote(4'b0001);
        repeat (5) vote(4'b0010);
        repeat (5) vote(4'b0100);
        vote(4'b1000);
        step(0, 1, 0, '0);
        @(negedge clk); chk("lit_rv_close_edge", int'(rv0), 0);
        for (int i = 1; i < N; i++) begin
            step(0, 0, 0, '0);
            @(negedge clk); chk($sformatf("lit_rv_early%0d", i), int'(rv0), 0);
        end
        step(0, 0, 0, '0);
        @(negedge clk);
        chk("lit_rv_rise", int'(rv0), 1);
        chk("lit_winner", int'(win0), 1);
        chk("lit_tie", int'(tie0), 1);
        chk("lit_sat_winner", int'(win1), 0);
        chk("lit_sat_tie", int'(tie1), 1);
        repeat (3) step(0, 0, 0, '0);
        @(negedge clk); chk("lit_rv_stays", int'(rv0), 1);

        // ballot with close in the same cycle, then reset mid-scan
        step(1, 0, 0, '0);
        step(0, 1, 1, 4'b0100);
        @(negedge clk);
        chk("lit_close_cast_state", int'(st0), 3);
        chk("lit_close_cast_cnt2", int'(counts0[23:16]), 1);
        chk("lit_close_cast_ack", int'(ack0), 1);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_state", int'(st0), 0);
        chk("lit_rst_counts", int'(counts0), 0);
        chk("lit_rst_total", int'(total0), 0);
        chk("lit_rst_rv", int'(rv0), 0);
        chk("lit_rst_winner", int'(win0), 0);
        chk("lit_rst_tie", int'(tie0), 0);
        step(0, 0, 0, '0);
        rst = 1'b0;
        step(0, 0, 0, '0);

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [N-1:0] s;
            bit o, c, ca;
            int mode;
            rst = ($urandom_range(0, 999) < 3);
            o   = ($urandom_range(0, 99) < 4);
            c   = ($urandom_range(0, 99) < 3);
            ca  = ($urandom_range(0, 99) < 45);
            mode = $urandom_range(0, 99);
            if (!ca && mode < 50)  s = '0;
            else if (mode < 70)    s = 4'(1 << $urandom_range(0, N - 1));
            else if (mode < 85)    s = '0;
            else                   s = 4'($urandom_range(0, 15));
            step(o, c, ca, s);
        end
        rst = 1'b0;
        step(0, 0, 0, '0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vote_tally_multi.md
VOTE_TALLY_MULTI -- requirements
Module: vote_tally_multi

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidates (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-candidate counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port open_i  input  1  start-election strobe, level sampled per cycle.
REQ-006 SHALL have port close_i  input  1  end-election strobe.
REQ-007 SHALL have port cast  input  1  ballot-submit strobe.
REQ-008 SHALL have port sel  input  NUM_CAND  candidate select buttons; bit i = candidate i.
REQ-009 SHALL have port vote_ack  output  1  one-cycle pulse: ballot counted.
REQ-010 SHALL have port vote_rej  output  1  one-cycle pulse: ballot refused.
REQ-011 SHALL have port counts  output  NUM_CAND*CNT_W  packed counters, candidate i at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port total  output  CNT_W+4  sum of accepted ballots.
REQ-013 SHALL have port state  output  2  FSM state: 00 IDLE, 01 OPEN, 10 HOLD, 11 CLOSED.
REQ-014 SHALL have port winner  output  4  index of winning candidate.
REQ-015 SHALL have port tie  output  1  more than one candidate holds the maximum count.
REQ-016 SHALL have port result_valid  output  1  winner/tie are final.
REQ-017 SHALL have port invalid_cnt  output  CNT_W  refused-ballot counter (present only per REQ-034).

Function
REQ-018 SHALL transition IDLE->OPEN or CLOSED->OPEN on open_i, clearing counts, total, invalid_cnt, winner, tie, result_valid in that same edge.
REQ-019 SHALL, in OPEN with cast=1 and sel exactly one-hot (bit k) and count[k] < 2^CNT_W-1, increment count[k] and total by 1, pulse vote_ack next cycle, and enter HOLD.
REQ-020 SHALL, in OPEN with cast=1 and sel zero or multi-hot, pulse vote_rej next cycle, change no counter except invalid_cnt, and enter HOLD.
REQ-021 SHALL, in OPEN with cast=1, valid sel and count[k] saturated, pulse vote_rej, leave count[k] and total unchanged, and enter HOLD.
REQ-022 SHALL stay in HOLD, ignoring cast, until cast=0 and sel=0 in the same cycle, then return to OPEN (one ballot per press).
REQ-023 SHALL ignore cast in IDLE and CLOSED: no ack, no rej, no counter change.
REQ-024 SHALL enter CLOSED on close_i from OPEN or HOLD; a ballot cast in the same OPEN cycle as close_i SHALL be processed, then state goes to CLOSED (not HOLD).
REQ-025 SHALL give open_i priority over close_i when both asserted in IDLE or CLOSED; close_i in IDLE ignored; open_i in OPEN/HOLD ignored.
REQ-026 SHALL, on entering CLOSED, scan candidates 0..NUM_CAND-1 one per cycle, tracking running maximum; result_valid SHALL rise exactly NUM_CAND cycles after the close edge and stay high until next open_i or reset.
REQ-027 SHALL select the lowest index among equal maxima as winner and set tie=1 when any other candidate equals that maximum; all-zero counts give winner=0, tie=1.
REQ-028 SHALL keep winner/tie at 0 while result_valid=0.
REQ-029 SHALL saturate invalid_cnt at 2^CNT_W-1.

Reset
REQ-030 SHALL on rst force state IDLE, counts, total, invalid_cnt, winner to 0, and tie, result_valid, vote_ack, vote_rej to 0.
REQ-031 SHALL on rst mid-scan or mid-HOLD abandon the operation with no partial result retained.
REQ-032 SHALL resume operation on the first rising clk edge after rst deasserts.

Configuration
REQ-033 SHALL use macro VOTE_TALLY_INVALID_CNT_EN to gate the refused-ballot counter.
REQ-034 SHALL, with the macro defined, increment invalid_cnt on every vote_rej from REQ-020 (not REQ-021); without it, invalid_cnt port is absent and no such register exists; all other behaviour identical.

Verification
REQ-035 SHALL test: NUM_CAND=4, open, cast sel=0010 then release -> count[1]=1, total=1, one vote_ack, state OPEN.
REQ-036 SHALL test: cast held 5 cycles with sel=0001 -> count[0]=1 only; sel=0110 -> vote_rej, counts unchanged, invalid_cnt=1 with macro.
REQ-037 SHALL test: CNT_W=2, four votes to candidate 2 -> count[2]=3, fourth gives vote_rej, total=3.
REQ-038 SHALL test: votes 3,5,5,1 then close_i -> result_valid after 4 cycles, winner=1, tie=1.
REQ-039 SHALL test: cast valid with close_i same cycle -> counted, state CLOSED; rst during scan -> state IDLE, all outputs 0.
